// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the fetch/redirect controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int          FETCH_XLEN     = 32;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] FETCH_NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_KILL = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_redirect_ctrl.sv
// PC owner and single-outstanding instruction fetch; a taken branch redirects the PC, kills the in-flight fetch and flushes IF/ID.
// Latency: 3 cycles from request issue to if_valid with zero-wait memory (REQ fire, response, capture).
// Backpressure: request address held until imem_req_ready; response refused while IF/ID is live and stalled.
module fetch_redirect_ctrl
    import fetch_pkg::*;
#(
    parameter int               XLEN     = FETCH_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(FETCH_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            br_en,
    input  logic [XLEN-1:0] br_target,
    input  logic            stall,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            imem_resp_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic            flush
);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] req_addr_q;
    logic            redir_pend_q;
    logic [XLEN-1:0] br_target_al;
    logic            req_fire;
    logic            resp_fire;

    // Word-align the redirect target; the low two bits are simply dropped.
    assign br_target_al  = br_target & ~XLEN'(3);
    assign req_fire      = imem_req_valid && imem_req_ready;
    assign resp_fire     = imem_resp_valid && imem_resp_ready;
    // req_addr_q only moves on entry to REQ, so it also names the outstanding fetch in WAIT.
    assign imem_req_addr = req_addr_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a redirect seen before or at request fire forces the response to be killed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (req_fire) begin
                    state_d = (redir_pend_q || br_en) ? S_KILL : S_WAIT;
                end
            end
            S_WAIT: begin
                if (resp_fire) begin
                    state_d = S_REQ;
                end else if (br_en) begin
                    state_d = S_KILL;
                end
            end
            S_KILL: begin
                if (resp_fire) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs per state; a redirect lets WAIT drain its response despite a stall.
    always_comb begin
        imem_req_valid  = 1'b0;
        imem_resp_ready = 1'b0;
        case (state_q)
            S_REQ:   imem_req_valid  = 1'b1;
            S_WAIT:  imem_resp_ready = !if_valid || !stall || br_en;
            S_KILL:  imem_resp_ready = 1'b1;
            default: ;
        endcase
    end

    // Next PC: a redirect always wins; otherwise advance past a fetch that was accepted.
    always_comb begin
        pc_d = pc_q;
        if (br_en) begin
            pc_d = br_target_al;
        end else if ((state_q == S_WAIT) && resp_fire) begin
            pc_d = req_addr_q + XLEN'(4);
        end
    end

    // PC, request address latched on REQ entry, and the pending-redirect flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            redir_pend_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if ((state_d == S_REQ) && (state_q != S_REQ)) begin
                req_addr_q <= pc_d;
            end
            if (state_d == S_KILL) begin
                redir_pend_q <= 1'b0;
            end else if ((state_q == S_REQ) && br_en && !req_fire) begin
                redir_pend_q <= 1'b1;
            end
        end
    end

    // IF/ID register and flush pulse; redirect beats capture, capture beats stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= XLEN'(FETCH_NOP);
            flush    <= 1'b0;
        end else begin
            flush <= br_en;
            if (br_en) begin
                if_valid <= 1'b0;
            end else if ((state_q == S_WAIT) && resp_fire) begin
                if_valid <= 1'b1;
                if_pc    <= req_addr_q;
                if_instr <= imem_resp_data;
            end else if (!stall) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl with a one-outstanding memory responder.
// Latency: responder answers the cycle after a request fires (zero-wait).
// Backpressure: request acceptance and response presentation controlled by knobs.
module tb_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br_en;
    logic [31:0] br_target;
    logic        stall;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;

    int errors = 0;
    int checks = 0;

    // responder state and per-cycle handshake snapshots
    logic        rdy_knob;
    logic        resp_en;
    logic        pend;
    logic [31:0] pend_addr;
    logic        req_fire_s;
    logic        resp_fire_s;
    logic [31:0] addr_s;

    always #5 clk = ~clk;

    fetch_redirect_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .br_en           (br_en),
        .br_target       (br_target),
        .stall           (stall),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_ready (imem_resp_ready),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .flush           (flush)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Present memory-side inputs for this cycle and note which handshakes will fire.
    task automatic drive();
        imem_req_ready  = rdy_knob;
        imem_resp_valid = pend && resp_en;
        imem_resp_data  = pend_addr ^ 32'h00A0_0093;
        #1;
        req_fire_s  = imem_req_valid && imem_req_ready;
        resp_fire_s = imem_resp_valid && imem_resp_ready;
        addr_s      = imem_req_addr;
    endtask

    task automatic edge_step();
        @(posedge clk);
        if (resp_fire_s) pend = 1'b0;
        if (req_fire_s) begin
            pend      = 1'b1;
            pend_addr = addr_s;
        end
        @(negedge clk);
    endtask

    task automatic cyc();
        drive();
        edge_step();
    endtask

    initial begin
        rst_n = 1'b1; br_en = 1'b0; br_target = '0; stall = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        rdy_knob = 1'b1; resp_en = 1'b1; pend = 1'b0; pend_addr = '0;
        req_fire_s = 1'b0; resp_fire_s = 1'b0; addr_s = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0000_0013);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_resp_ready", 32'(imem_resp_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // zero-wait streaming fetch
        cyc();
        chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_addr0", imem_req_addr, 32'h0);
        cyc();
        chk("t1_wait_no_req", 32'(imem_req_valid), 32'd0);
        cyc();
        chk("t1_if_valid", 32'(if_valid), 32'd1);
        chk("t1_if_pc", if_pc, 32'h0);
        chk("t1_if_instr", if_instr, 32'h00A0_0093);
        chk("t1_addr4", imem_req_addr, 32'h4);
        chk("t1_flush", 32'(flush), 32'd0);
        cyc(); cyc();
        chk("t1_addr8", imem_req_addr, 32'h8);
        chk("t1_if_pc4", if_pc, 32'h4);
        chk("t1_if_instr4", if_instr, 32'h00A0_0097);

        // redirect while the request is back-pressured
        rst_n = 1'b0; pend = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; rdy_knob = 1'b0;
        cyc();
        br_en = 1'b1; br_target = 32'h100;
        cyc();
        br_en = 1'b0;
        chk("t2_addr_hold", imem_req_addr, 32'h0);
        chk("t2_valid_hold", 32'(imem_req_valid), 32'd1);
        chk("t2_flush", 32'(flush), 32'd1);
        cyc();
        chk("t2_flush_once", 32'(flush), 32'd0);
        chk("t2_addr_hold2", imem_req_addr, 32'h0);
        cyc();
        rdy_knob = 1'b1;
        cyc();
        chk("t2_kill_no_req", 32'(imem_req_valid), 32'd0);
        cyc();
        chk("t2_redir_valid", 32'(imem_req_valid), 32'd1);
        chk("t2_redir_addr", imem_req_addr, 32'h100);
        chk("t2_discarded", 32'(if_valid), 32'd0);
        cyc(); cyc();
        chk("t2_cap_valid", 32'(if_valid), 32'd1);
        chk("t2_cap_pc", if_pc, 32'h100);
        chk("t2_cap_instr", if_instr, 32'h00A0_0193);

        // redirect in WAIT coinciding with the response
        cyc();
        br_en = 1'b1; br_target = 32'h200;
        cyc();
        br_en = 1'b0;
        chk("t3_if_valid", 32'(if_valid), 32'd0);
        chk("t3_flush", 32'(flush), 32'd1);
        chk("t3_addr", imem_req_addr, 32'h200);

        // stall holds IF/ID and refuses the response
        cyc(); cyc();
        chk("t4_cap_pc", if_pc, 32'h200);
        stall = 1'b1;
        cyc();
        drive();
        chk("t4_resp_ready", 32'(imem_resp_ready), 32'd0);
        edge_step();
        chk("t4_hold_valid", 32'(if_valid), 32'd1);
        chk("t4_hold_pc", if_pc, 32'h200);
        chk("t4_hold_instr", if_instr, 32'h00A0_0293);
        stall = 1'b0;
        cyc();
        chk("t4_rel_pc", if_pc, 32'h204);
        chk("t4_rel_instr", if_instr, 32'h00A0_0297);
        chk("t4_next_addr", imem_req_addr, 32'h208);

        // back-to-back redirects, last (unaligned) target wins, then PC wrap
        br_en = 1'b1; br_target = 32'h300;
        cyc();
        chk("t5_flush1", 32'(flush), 32'd1);
        br_target = 32'hFFFF_FFFE;
        cyc();
        br_en = 1'b0;
        chk("t5_flush2", 32'(flush), 32'd1);
        chk("t5_last_wins", imem_req_addr, 32'hFFFF_FFFC);
        cyc();
        chk("t5_flush_end", 32'(flush), 32'd0);
        cyc();
        chk("t5_top_pc", if_pc, 32'hFFFF_FFFC);
        chk("t5_top_instr", if_instr, 32'hFF5F_FF6F);
        chk("t5_wrap_addr", imem_req_addr, 32'h0);

        // asynchronous reset while waiting on a response
        cyc(); cyc(); cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6_addr", imem_req_addr, 32'h0);
        chk("t6_if_valid", 32'(if_valid), 32'd0);
        chk("t6_if_pc", if_pc, 32'h0);
        chk("t6_if_instr", if_instr, 32'h0000_0013);
        chk("t6_resp_ready", 32'(imem_resp_ready), 32'd0);
        pend = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("t6_first_valid", 32'(imem_req_valid), 32'd1);
        chk("t6_first_addr", imem_req_addr, 32'h0);
        cyc(); cyc();
        chk("t6_cap_pc", if_pc, 32'h0);
        chk("t6_cap_instr", if_instr, 32'h00A0_0093);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Owns the program counter and the instruction-fetch handshake.
- Consumes the branch-taken strobe (br_en) and the target address resolved in EX; on redirect it loads the new PC, kills the in-flight fetch and flushes IF/ID.
- Sits between the hazard/EX stage and instruction memory, one outstanding request at a time.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  asynchronous active-low reset
br_en  in  1  branch/jump taken this cycle (from EX)
br_target  in  XLEN  redirect address, valid when br_en=1
stall  in  1  hazard stall; IF/ID output must hold
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  XLEN  fetch address
imem_req_ready  in  1  memory accepts request
imem_resp_valid  in  1  fetch data valid
imem_resp_data  in  XLEN  fetched instruction
imem_resp_ready  out  1  controller accepts response
if_valid  out  1  IF/ID register holds a live instruction
if_pc  out  XLEN  PC of if_instr
if_instr  out  XLEN  instruction to decode
flush  out  1  one-cycle pulse: squash younger pipeline stages

Behaviour:
- Clock clk; reset rst_n asynchronous, active-low. Everything below is synchronous to the rising edge of clk.
- Reset values: pc=RESET_PC, state=IDLE, imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP), flush=0, redir_pend=0.
- States: IDLE, REQ, WAIT, KILL.
- IDLE -> REQ unconditionally on the first edge after reset release.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - addr is held stable while valid&&!ready, even if br_en arrives.
  - On fire (valid&&ready): go to WAIT, or to KILL if redir_pend or br_en.
- WAIT:
  - imem_resp_ready = !if_valid || !stall || br_en.
  - On resp fire without br_en: if_valid<=1, if_pc<=req_pc, if_instr<=data, pc<=req_pc+4, then go to REQ.
  - On br_en with or without resp fire: pc<=target; resp fire -> REQ (data discarded), else -> KILL.
- KILL:
  - imem_resp_ready=1; the next response is discarded, then go to REQ.
  - br_en in KILL only updates pc.
- Redirect:
  - On br_en, at the next edge: pc<={br_target[XLEN-1:2],2'b00}, flush<=1 for exactly one cycle, if_valid<=0.
  - br_en in REQ before fire sets redir_pend; it clears on entering KILL.
- Output register when no redirect: if_valid<=0 when !stall and no response is captured; holds when stall=1. br_en beats stall.
- pc+4 wraps modulo 2^XLEN: 32'hFFFF_FFFC -> 32'h0000_0000.
- imem_resp_ready=0 in IDLE/REQ; responses arriving there are ignored.
- Back-to-back br_en: the last target wins; flush stays high for each cycle of br_en (delayed by one cycle).
- Reset asserted mid-operation returns everything to reset values immediately; no response is awaited afterwards.
- Latency: minimum 3 cycles from request issue to if_valid with zero-wait memory (REQ fire, resp, capture).

Decomposition:
- Shared package/header fetch_pkg: XLEN, RESET_PC default, NOP encoding 32'h0000_0013, state encodings (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, KILL=2'd3).
- No sub-module; a single FSM plus PC/IF-ID registers.

Test Plan:
- Reset release, zero-wait memory returning 32'h00A00093 -> imem_req_addr=0, then 4, 8; if_valid=1 with if_pc=0, if_instr=32'h00A00093; flush stays 0.
- imem_req_ready held low 3 cycles while br_en=1 with br_target=32'h100 -> addr stays 0 until fire; response discarded; next request addr=32'h100; flush pulses once.
- br_en in WAIT with target 32'h200 in the same cycle as imem_resp_valid -> data not captured, if_valid=0, next request addr=32'h200.
- stall=1 with if_valid=1 and a response pending -> imem_resp_ready=0; if_pc/if_instr hold; on release the response is captured next edge.
- PC at 32'hFFFF_FFFC fetched -> next request addr=32'h0000_0000.
- rst_n pulled low during WAIT -> outputs return to reset values asynchronously; after release the first request addr=RESET_PC.
